rgb_pattern_sequencer: RTL and testbench

- Drives the three board LED pins from a small pattern table instead of raw counter bits.
- Sequences up to NUM_STEPS steps. Each step holds a per-channel PWM duty (R/G/B) for a programmed number of prescaled ticks.
- Clocked from the internal oscillator net (OSCH, 2.08 MHz nominal). led[2:0] feeds the top-level inout pin assigns.
- The pattern table is loaded through a simple write port while idle.

---
 rtl/rgb_pattern_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_rgb_pattern_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pattern_sequencer
// Purpose  : Plays a small table of {hold, R, G, B} steps onto three PWM LEDs.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pattern_sequencer #(
    parameter int TICK_DIV  = 20800,
    parameter int NUM_STEPS = 8,
    parameter int PWM_W     = 4,
    parameter int HOLD_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_STEPS)-1:0]   wr_addr,
    input  logic [3*PWM_W+HOLD_W-1:0]      wr_data,
    output logic                           wr_ready,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           loop,
    input  logic [$clog2(NUM_STEPS):0]     len,
    output logic [2:0]                     led,
    output logic                           busy,
    output logic [$clog2(NUM_STEPS)-1:0]   step_idx,
    output logic                           done
);

    localparam int              c_AW        = $clog2(NUM_STEPS);
    localparam int              c_DW        = 3*PWM_W + HOLD_W;
    localparam int              c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_AW:0]   c_MAX_LEN   = (c_AW+1)'(NUM_STEPS);
    localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_AW-1:0]     step_q, step_d;
    logic [c_AW:0]       len_q, len_d;
    logic                loop_q, loop_d;
    logic [c_PW-1:0]     presc_q, presc_d;
    logic [PWM_W-1:0]    pwm_q, pwm_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [PWM_W-1:0]    duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
    logic [2:0]          led_q, led_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_ready_q, wr_ready_d;

    // Pattern table: no reset so contents survive rst.
    logic [c_DW-1:0]     table_q [NUM_STEPS];

    logic [c_DW-1:0]     w_entry;
    logic [HOLD_W-1:0]   w_hold;
    logic                w_tick;
    logic                w_last;

    assign w_entry = table_q[step_q];
    assign w_hold  = w_entry[c_DW-1 -: HOLD_W];
    assign w_tick  = (presc_q == c_TICK_LAST);
    assign w_last  = ({1'b0, step_q} == (len_q - (c_AW+1)'(1)));

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        len_d      = len_q;
        loop_d     = loop_q;
        presc_d    = presc_q;
        pwm_d      = pwm_q;
        hold_d     = hold_q;
        duty_r_d   = duty_r_q;
        duty_g_d   = duty_g_q;
        duty_b_d   = duty_b_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop && (len != '0)) begin
                    state_d = S_LOAD;
                    loop_d  = loop;
                    len_d   = (len > c_MAX_LEN) ? c_MAX_LEN : len;
                    step_d  = '0;
                end
            end
            S_LOAD: begin
                duty_r_d = w_entry[3*PWM_W-1 -: PWM_W];
                duty_g_d = w_entry[2*PWM_W-1 -: PWM_W];
                duty_b_d = w_entry[PWM_W-1:0];
                hold_d   = (w_hold == '0) ? HOLD_W'(1) : w_hold;
                presc_d  = '0;
                pwm_d    = '0;
                state_d  = stop ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                pwm_d = pwm_q + PWM_W'(1);
                if (w_tick) begin
                    presc_d = '0;
                    hold_d  = hold_q - HOLD_W'(1);
                    if (hold_q == HOLD_W'(1)) begin
                        if (!w_last) begin
                            step_d  = step_q + c_AW'(1);
                            state_d = S_LOAD;
                        end else if (loop_q) begin
                            step_d  = '0;
                            state_d = S_LOAD;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    presc_d = presc_q + c_PW'(1);
                end
                // Abort overrides any step advance and suppresses done.
                if (stop) begin
                    state_d = S_IDLE;
                    step_d  = step_q;
                    done_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Compare against next-cycle counter so led lines up with pwm_cnt.
        led_d      = (state_d == S_HOLD) ?
                     {(pwm_d < duty_r_d), (pwm_d < duty_g_d), (pwm_d < duty_b_d)} : 3'b000;
        busy_d     = (state_d != S_IDLE);
        wr_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            presc_q    <= '0;
            pwm_q      <= '0;
            hold_q     <= '0;
            duty_r_q   <= '0;
            duty_g_q   <= '0;
            duty_b_q   <= '0;
            led_q      <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            presc_q    <= presc_d;
            pwm_q      <= pwm_d;
            hold_q     <= hold_d;
            duty_r_q   <= duty_r_d;
            duty_g_q   <= duty_g_d;
            duty_b_q   <= duty_b_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && (state_q == S_IDLE)) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_ready = wr_ready_q;
    assign step_idx = step_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pattern_sequencer
// Purpose  : Randomized self-checking bench with a timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_pattern_sequencer;

    localparam int TICK_DIV  = 4;
    localparam int NUM_STEPS = 8;
    localparam int PWM_W     = 4;
    localparam int HOLD_W    = 8;
    localparam int AW        = 3;
    localparam int DW        = 3*PWM_W + HOLD_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop = 1'b0;
    logic [AW:0]   len = '0;
    logic [2:0]    led;
    logic          busy;
    logic [AW-1:0] step_idx;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference copy of the table as the bench believes it should be.
    logic [DW-1:0] model [NUM_STEPS];

    rgb_pattern_sequencer #(
        .TICK_DIV (TICK_DIV),
        .NUM_STEPS(NUM_STEPS),
        .PWM_W    (PWM_W),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ready(wr_ready),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .len     (len),
        .led     (led),
        .busy    (busy),
        .step_idx(step_idx),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input int h, input int r, input int g, input int b);
        logic [DW-1:0] e;
        e = {h[HOLD_W-1:0], r[PWM_W-1:0], g[PWM_W-1:0], b[PWM_W-1:0]};
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = e;
        tick();
        wr_en   = 1'b0;
        model[a] = e;
    endtask

    // Plays one run and compares every cycle against the timeline derived from
    // the table: per step, 1 LOAD cycle then max(hold,1)*TICK_DIV HOLD cycles.
    // stop_at > 0 asserts stop for the edge after that many run cycles.
    task automatic play(input int len_in, input bit loop_in, input int stop_at, input string tag);
        int eff, idx, h, hc, cyc, stop_idx, last_idx, dr, dg, db, ph;
        logic [DW-1:0] e;
        logic [8:0] got, exp_v;
        eff      = (len_in > NUM_STEPS) ? NUM_STEPS : len_in;
        cyc      = 0;
        stop_idx = -1;
        last_idx = eff - 1;
        len   = len_in[AW:0];
        loop  = loop_in;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 64; p++) begin
            if (!loop_in && p == eff) break;
            idx = p % eff;
            e   = model[idx];
            h   = int'(e[DW-1 -: HOLD_W]);
            hc  = ((h == 0) ? 1 : h) * TICK_DIV;
            dr  = int'(e[3*PWM_W-1 -: PWM_W]);
            dg  = int'(e[2*PWM_W-1 -: PWM_W]);
            db  = int'(e[PWM_W-1:0]);
            got   = {busy, done, wr_ready, step_idx, led};
            exp_v = {1'b1, 1'b0, 1'b0, idx[AW-1:0], 3'b000};
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL %s load p=%0d: got %b expected %b", tag, p, got, exp_v);
            end
            cyc++;
            if (cyc == stop_at) stop_idx = idx;
            for (int k = 0; k < hc && stop_idx < 0; k++) begin
                start   = ($urandom_range(0, 3) == 0);
                len     = (AW+1)'($urandom);
                loop    = 1'($urandom);
                wr_en   = ($urandom_range(0, 2) == 0);
                wr_addr = AW'($urandom);
                wr_data = DW'($urandom);
                tick();
                start = 1'b0;
                wr_en = 1'b0;
                ph    = k % (1 << PWM_W);
                got   = {busy, done, wr_ready, step_idx, led};
                exp_v = {1'b1, 1'b0, 1'b0, idx[AW-1:0], (ph < dr), (ph < dg), (ph < db)};
                n_checks++;
                if (got !== exp_v) begin
                    n_errors++;
                    $display("FAIL %s hold p=%0d k=%0d: got %b expected %b", tag, p, k, got, exp_v);
                end
                cyc++;
                if (cyc == stop_at) stop_idx = idx;
            end
            if (stop_idx >= 0) break;
            tick();
        end
        if (stop_idx >= 0) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            last_idx = stop_idx;
            got   = {busy, done, wr_ready, step_idx, led};
            exp_v = {1'b0, 1'b0, 1'b1, last_idx[AW-1:0], 3'b000};
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL %s stop: got %b expected %b", tag, got, exp_v);
            end
        end else begin
            got   = {busy, done, wr_ready, step_idx, led};
            exp_v = {1'b0, 1'b1, 1'b1, last_idx[AW-1:0], 3'b000};
            n_checks++;
            if (got !== exp_v) begin
                n_errors++;
                $display("FAIL %s done: got %b expected %b", tag, got, exp_v);
            end
        end
        tick();
        got   = {busy, done, wr_ready, step_idx, led};
        exp_v = {1'b0, 1'b0, 1'b1, last_idx[AW-1:0], 3'b000};
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s idle_after: got %b expected %b", tag, got, exp_v);
        end
    endtask

    task automatic test_reset();
        logic [8:0] got;
        got = {busy, done, wr_ready, step_idx, led};
        n_checks++;
        if (got !== 9'b001_000_000) begin
            n_errors++;
            $display("FAIL reset_held: got %b expected %b", got, 9'b001_000_000);
        end
        rst = 1'b0;
        tick();
        got = {busy, done, wr_ready, step_idx, led};
        n_checks++;
        if (got !== 9'b001_000_000) begin
            n_errors++;
            $display("FAIL reset_released: got %b expected %b", got, 9'b001_000_000);
        end
    endtask

    task automatic test_single();
        write_entry(0, 2, 15, 0, 8);
        play(1, 1'b0, 0, "single");
    endtask

    task automatic test_loop();
        for (int i = 0; i < 3; i++)
            write_entry(i, i + 1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        play(3, 1'b1, 5 + 9 + 13 + 3, "loop");
    endtask

    task automatic test_stop();
        play(3, 1'b1, 10, "stop_mid_hold");
    endtask

    task automatic test_hold_zero();
        write_entry(0, 0, 15, 7, 3);
        play(1, 1'b0, 0, "hold_zero");
    endtask

    task automatic test_len_zero();
        len   = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({busy, wr_ready, led} !== 5'b01_000) begin
                n_errors++;
                $display("FAIL len_zero: got %b expected %b", {busy, wr_ready, led}, 5'b01_000);
            end
            tick();
        end
    endtask

    task automatic test_start_stop();
        len   = (AW+1)'(2);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({busy, wr_ready, done} !== 3'b010) begin
                n_errors++;
                $display("FAIL start_stop: got %b expected %b", {busy, wr_ready, done}, 3'b010);
            end
            tick();
        end
    endtask

    task automatic test_len_clamp();
        for (int i = 0; i < NUM_STEPS; i++)
            write_entry(i, $urandom_range(0, 2), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        play(15, 1'b0, 0, "len_clamp");
    endtask

    task automatic test_back_to_back();
        play(2, 1'b0, 0, "b2b_a");
        play(2, 1'b0, 0, "b2b_b");
    endtask

    task automatic test_random();
        int l, sa;
        bit lp;
        for (int i = 0; i < 6; i++) begin
            l  = $urandom_range(1, 15);
            lp = 1'($urandom_range(0, 1));
            sa = lp ? $urandom_range(1, 60) : (($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0);
            play(l, lp, sa, "random");
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] got;
        write_entry(0, 1, 15, 15, 15);
        write_entry(1, 1, 15, 9, 15);
        len   = (AW+1)'(2);
        loop  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        got = {busy, done, wr_ready, step_idx, led};
        n_checks++;
        if (got !== 9'b001_000_000) begin
            n_errors++;
            $display("FAIL async_reset: got %b expected %b", got, 9'b001_000_000);
        end
        tick();
        #2;
        rst = 1'b0;
        tick();
        play(2, 1'b0, 0, "after_reset");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_loop();
        test_stop();
        test_hold_zero();
        test_len_zero();
        test_start_stop();
        test_len_clamp();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
